// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding and default constants.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2
  } mon_state_e;

  localparam int unsigned RATIO_DEF      = 4;
  localparam int unsigned LOCK_COUNT_DEF = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain for an asynchronous level, plus one history flop and combinational
// rise/fall detection on the synchronized value.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_det,
  output logic fall_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= s;
    end
  end

  assign rise_det = s & ~prev_q;
  assign fall_det = ~s & prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Monitors a divided clock in the fast clk domain: edge strobes, rise-to-rise period, lock/error.
// Optional duty-cycle checking is enabled by defining CLK_DIV_MONITOR_DUTY_CHECK_EN.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned RATIO       = RATIO_DEF,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             error
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] RatioCnt   = CNT_W'(RATIO);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(2 * RATIO);
  localparam logic [3:0]       LockTarget = 4'(LOCK_COUNT);

  logic rise_det, fall_det;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk     (clk),
    .reset   (reset),
    .din     (slow_clk_in),
    .rise_det(rise_det),
    .fall_det(fall_det)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, measured;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] period_d;
  logic             period_valid_d, locked_d, error_d;
  logic             timeout, period_ok, high_ok;

  // Saturating increment doubles as the measured period on a rise.
  assign measured = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_d    = rise_det ? '0 : measured;
  assign timeout  = (state_q != StIdle) && (cnt_q == TimeoutCnt);

`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] HalfRatio = CNT_W'(RATIO / 2);

  logic [CNT_W-1:0] high_q;
  logic             duty_err_d;

  // cnt restarts on every rise, so its count at the fall is the high time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_q <= '0;
    end else if (fall_det) begin
      high_q <= measured;
    end
  end

  assign high_ok    = (high_q == HalfRatio);
  assign duty_err_d = rise_det && !timeout && (state_q != StIdle) && !high_ok;
`else
  assign high_ok = 1'b1;
`endif

  assign period_ok = (measured == RatioCnt) && high_ok;

  always_comb begin
    state_d        = state_q;
    match_d        = match_q;
    period_d       = period;
    period_valid_d = 1'b0;
    error_d        = 1'b0;
    if (timeout) begin
      state_d = StIdle;
      match_d = '0;
      error_d = (state_q == StLocked);
    end else if (rise_det) begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcquire;
          match_d = '0;
        end
        StAcquire: begin
          period_valid_d = 1'b1;
          period_d       = measured;
          if (period_ok) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LockTarget) state_d = StLocked;
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          period_valid_d = 1'b1;
          period_d       = measured;
          if (!period_ok) begin
            error_d = 1'b1;
            state_d = StAcquire;
            match_d = '0;
          end
        end
        default: begin
          state_d = StIdle;
          match_d = '0;
        end
      endcase
    end
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      match_q      <= '0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
      rise_pulse   <= rise_det;
      fall_pulse   <= fall_det;
      period       <= period_d;
      period_valid <= period_valid_d;
      locked       <= locked_d;
      error        <= error_d;
    end
  end

`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_err <= 1'b0;
    end else begin
      duty_err <= duty_err_d;
    end
  end
`endif

endmodule
